// File: rtl/gf163_pkg.sv
// rtl/gf163_pkg.sv - shared constants, types and halve-mod-f helper for the GF(2^163) divider
package gf163_pkg;

    localparam int M = 163;

    // f(z) = z^163 + z^7 + z^6 + z^3 + 1, including the z^M term
    localparam logic [M:0] POLY = (164'd1 << 163) | 164'hC9;

    localparam int DIV_MAX_CYC = 660;

    typedef logic [M-1:0] fe_t;
    typedef logic [M:0]   fex_t;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT_U = 3'd1;
    localparam logic [2:0] S_SHIFT_V = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;

    // Divide a field element by z: an odd element first gets f added so the shift is exact
    function automatic fe_t halve(input fe_t g);
        fex_t t;
        t = {1'b0, g};
        if (g[0]) begin
            t = t ^ POLY;
        end
        return t[M:1];
    endfunction

endpackage

// File: rtl/gf2_lead_one.sv
// rtl/gf2_lead_one.sv - combinational leading-one index of a binary polynomial
module gf2_lead_one #(
    parameter int W = 164
) (
    input  logic [W-1:0] vec_i,
    output logic [7:0]   idx_o
);

    // Scan upward so the highest set bit is the last to write the index
    always_comb begin
        idx_o = 8'd0;
        for (int i = 0; i < W; i++) begin
            if (vec_i[i]) begin
                idx_o = 8'(i);
            end
        end
    end

endmodule

// File: rtl/gf163_div.sv
// rtl/gf163_div.sv - sequential GF(2^163) divider q = x / y using binary extended Euclid
module gf163_div
    import gf163_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [162:0] x,
    input  logic [162:0] y,
    output logic         busy,
    output logic         done,
    output logic [162:0] q,
    output logic         div_zero
);

    localparam fex_t ONE_X = fex_t'(1);

    logic [2:0] state_q, state_d;
    fex_t       u_q, u_d, v_q, v_d;
    fe_t        g1_q, g1_d, g2_q, g2_d;
    fe_t        res_q, res_d;
    logic       dz_q, dz_d;
    logic       done_q, done_d;
    logic [7:0] deg_u, deg_v;

    gf2_lead_one #(.W(M + 1)) u_lead (.vec_i(u_q), .idx_o(deg_u));
    gf2_lead_one #(.W(M + 1)) v_lead (.vec_i(v_q), .idx_o(deg_v));

    // Invariants kept: g1*y == x*u and g2*y == x*v (mod f); finish when u or v reaches 1
    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        g1_d    = g1_q;
        g2_d    = g2_q;
        res_d   = res_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (y == '0) begin
                        res_d   = '0;
                        dz_d    = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        u_d     = {1'b0, y};
                        v_d     = POLY;
                        g1_d    = x;
                        g2_d    = '0;
                        state_d = S_SHIFT_U;
                    end
                end
            end
            S_SHIFT_U: begin
                if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    g1_d = halve(g1_q);
                end else begin
                    state_d = S_SHIFT_V;
                end
            end
            S_SHIFT_V: begin
                if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    g2_d = halve(g2_q);
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (u_q == ONE_X) begin
                    res_d   = g1_q;
                    dz_d    = 1'b0;
                    state_d = S_FIN;
                end else if (v_q == ONE_X) begin
                    res_d   = g2_q;
                    dz_d    = 1'b0;
                    state_d = S_FIN;
                end else if (deg_u > deg_v) begin
                    u_d     = u_q ^ v_q;
                    g1_d    = g1_q ^ g2_q;
                    state_d = S_SHIFT_U;
                end else begin
                    v_d     = v_q ^ u_q;
                    g2_d    = g2_q ^ g1_q;
                    state_d = S_SHIFT_V;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            u_q     <= '0;
            v_q     <= '0;
            g1_q    <= '0;
            g2_q    <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            g1_q    <= g1_d;
            g2_q    <= g2_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign q        = res_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_gf163_div.sv
// tb/tb_gf163_div.sv - scoreboard bench for gf163_div against a polynomial-multiply reference
module tb_gf163_div;

    localparam logic [163:0] F_POLY  = (164'd1 << 163) | 164'hC9;
    localparam int           LAT_MAX = 660;
    localparam int           N_RAND  = 110;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [162:0] x = '0;
    logic [162:0] y = '0;
    logic         busy, done, div_zero;
    logic [162:0] q;

    gf163_div dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .q(q), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [162:0] x;
        logic [162:0] y;
        logic         chk_q;
        logic [162:0] exp_q;
        int           exp_lat;
        int           acc;
    } exp_t;

    exp_t sb[$];

    // Schoolbook polynomial product reduced modulo f
    function automatic logic [162:0] ref_mul(input logic [162:0] a, input logic [162:0] b);
        logic [163:0] acc;
        acc = '0;
        for (int i = 162; i >= 0; i--) begin
            acc = acc << 1;
            if (acc[163]) acc = acc ^ F_POLY;
            if (b[i]) acc = acc ^ {1'b0, a};
        end
        return acc[162:0];
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[162:0];
    endfunction

    task automatic check_fe(input string name, input logic [162:0] act, input logic [162:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every done pops one expectation and checks result, flags and latency
    always @(negedge clk) begin
        exp_t e;
        int lat;
        if (rst_n && done) begin
            check_int("done_pulse", int'(prev_done), 0);
            check_int("busy_at_done", int'(busy), 0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                e = sb.pop_front();
                lat = cyc - e.acc;
                if (e.y == '0) begin
                    check_int("div_zero_set", int'(div_zero), 1);
                    check_fe("q_on_div_zero", q, '0);
                end else begin
                    check_int("div_zero_clear", int'(div_zero), 0);
                    check_fe("q_times_y", ref_mul(q, e.y), e.x);
                    if (e.chk_q) check_fe("q_exact", q, e.exp_q);
                end
                if (e.exp_lat > 0) check_int("latency", lat, e.exp_lat);
                else check_int("latency_bound", int'(lat <= LAT_MAX), 1);
            end
            done_cnt++;
        end
        prev_done = done;
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [162:0] xi, input logic [162:0] yi,
                         input logic chk, input logic [162:0] eq, input int el);
        exp_t e;
        int guard;
        guard = 0;
        while (busy && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        x = xi;
        y = yi;
        start = 1'b1;
        e.x = xi;
        e.y = yi;
        e.chk_q = chk;
        e.exp_q = eq;
        e.exp_lat = el;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        x = ~xi;
        y = ~yi;
    endtask

    task automatic wait_done();
        int n0;
        int k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < LAT_MAX + 20) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == n0) begin
            total++;
            bad++;
            $display("FAIL done_timeout actual=%0d expected<=%0d", k, LAT_MAX);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [162:0] zinv;
        logic [162:0] top;
        logic [162:0] rx;
        zinv = (163'd1 << 162) | 163'h64;
        top = 163'd1 << 162;

        repeat (3) @(negedge clk);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check_fe("rst_q", q, '0);
        check_int("rst_div_zero", int'(div_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(163'd1, 163'd1, 1'b1, 163'd1, 4);
        wait_done();

        // start pulsed while busy must be ignored and q must hold the last result
        issue(rand163(), rand163() | top | 163'd2, 1'b0, '0, 0);
        @(negedge clk);
        check_int("busy_mid_op", int'(busy), 1);
        check_fe("q_held_while_busy", q, 163'd1);
        x = rand163();
        y = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        issue(163'd2, 163'd1, 1'b1, 163'd2, 0);
        wait_done();
        issue(163'd1, 163'd2, 1'b1, zinv, 0);
        wait_done();
        issue(rand163(), '0, 1'b0, '0, 1);
        wait_done();
        issue(163'd1, 163'd1, 1'b1, 163'd1, 4);
        wait_done();
        issue('0, rand163() | top, 1'b1, '0, 0);
        wait_done();
        issue(rand163(), top, 1'b0, '0, 0);
        wait_done();
        issue(163'd1, top, 1'b0, '0, 0);
        wait_done();

        for (int i = 0; i < N_RAND; i++) begin
            rx = rand163();
            if (rx == '0) rx = 163'd1;
            issue(rand163(), rx, 1'b0, '0, 0);
            wait_done();
        end

        // reset mid-operation: abandon, no done, then a fresh start right away
        issue(rand163(), rand163() | top | 163'd2, 1'b0, '0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_int("midrst_busy", int'(busy), 0);
        check_fe("midrst_q", q, '0);
        check_int("midrst_done", int'(done), 0);
        sb.delete();
        rst_n = 1'b1;
        issue(163'd2, 163'd1, 1'b1, 163'd2, 0);
        wait_done();

        repeat (10) @(negedge clk);
        check_int("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
